// File: rtl/dnn_job_driver_if.sv
// Handshake bundle of dnn_job_driver: input vector stream, accelerator start/done port and
// result stream. master is the driver's view, slave is the surrounding system's view.
interface dnn_job_driver_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;

  logic        acc_start;
  logic [7:0]  acc_in_0;
  logic [7:0]  acc_in_1;
  logic [7:0]  acc_in_2;
  logic [7:0]  acc_in_3;
  logic        acc_done;
  logic        acc_valid;
  logic [15:0] acc_out_0;
  logic [15:0] acc_out_1;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  modport master (
    input  in_valid, in_vec, acc_done, acc_valid, acc_out_0, acc_out_1, res_ready,
    output in_ready, acc_start, acc_in_0, acc_in_1, acc_in_2, acc_in_3, res_valid, res_data
  );

  modport slave (
    output in_valid, in_vec, acc_done, acc_valid, acc_out_0, acc_out_1, res_ready,
    input  in_ready, acc_start, acc_in_0, acc_in_1, acc_in_2, acc_in_3, res_valid, res_data
  );
endinterface

// File: rtl/dnn_job_driver.sv
// Queues 4-byte input vectors, launches the DNN accelerator once per vector and collects
// {acc_out_1, acc_out_0} into a first-word-fall-through result queue.
module dnn_job_driver #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  dnn_job_driver_if.master job_if,
  input  logic             clear_err_i,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic [7:0]       batch_count_o
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned RAW = $clog2(RES_DEPTH);
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e         state_q, state_d;
  logic           start_q, start_d;
  logic [31:0]    opnd_q, opnd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [7:0]     batch_q, batch_d;

  // Input vector queue; pointers carry one extra wrap bit to tell full from empty.
  logic [31:0] iq_mem_q [DEPTH];
  logic [AW:0] iq_wr_q, iq_rd_q;
  logic        iq_empty, iq_full, iq_push, iq_pop;
  logic [31:0] iq_head;

  assign iq_empty = (iq_wr_q == iq_rd_q);
  assign iq_full  = (iq_wr_q[AW] != iq_rd_q[AW]) && (iq_wr_q[AW-1:0] == iq_rd_q[AW-1:0]);
  assign iq_push  = job_if.in_valid && !iq_full;
  assign iq_head  = iq_mem_q[iq_rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (iq_push) iq_mem_q[iq_wr_q[AW-1:0]] <= job_if.in_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq_wr_q <= '0;
      iq_rd_q <= '0;
    end else begin
      if (iq_push) iq_wr_q <= iq_wr_q + (AW+1)'(1);
      if (iq_pop)  iq_rd_q <= iq_rd_q + (AW+1)'(1);
    end
  end

  // Result queue, written only by the FSM.
  logic [31:0]  rq_mem_q [RES_DEPTH];
  logic [RAW:0] rq_wr_q, rq_rd_q;
  logic         rq_empty, rq_full, rq_push, rq_pop;

  assign rq_empty = (rq_wr_q == rq_rd_q);
  assign rq_full  = (rq_wr_q[RAW] != rq_rd_q[RAW]) && (rq_wr_q[RAW-1:0] == rq_rd_q[RAW-1:0]);
  assign rq_pop   = !rq_empty && job_if.res_ready;

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem_q[rq_wr_q[RAW-1:0]] <= {job_if.acc_out_1, job_if.acc_out_0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_wr_q <= '0;
      rq_rd_q <= '0;
    end else begin
      if (rq_push) rq_wr_q <= rq_wr_q + (RAW+1)'(1);
      if (rq_pop)  rq_rd_q <= rq_rd_q + (RAW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      batch_q <= batch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    err_d   = clear_err_i ? 1'b0 : err_q;
    batch_d = batch_q;
    iq_pop  = 1'b0;
    rq_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!iq_empty && !job_if.acc_done) begin
          state_d = StRun;
          start_d = 1'b1;
          opnd_d  = iq_head;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (job_if.acc_done && job_if.acc_valid) begin
          // With the result queue full, start stays high and the accelerator parks in done.
          if (!rq_full) begin
            rq_push = 1'b1;
            iq_pop  = 1'b1;
            batch_d = batch_q + 8'd1;
            start_d = 1'b0;
            state_d = StDrain;
          end
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          iq_pop  = 1'b1;
          start_d = 1'b0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDrain: begin
        if (!job_if.acc_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign job_if.in_ready  = !iq_full;
  assign job_if.acc_start = start_q;
  assign job_if.acc_in_0  = opnd_q[7:0];
  assign job_if.acc_in_1  = opnd_q[15:8];
  assign job_if.acc_in_2  = opnd_q[23:16];
  assign job_if.acc_in_3  = opnd_q[31:24];
  assign job_if.res_valid = !rq_empty;
  assign job_if.res_data  = rq_empty ? 32'h0 : rq_mem_q[rq_rd_q[RAW-1:0]];

  assign busy_o        = (state_q != StIdle) || !iq_empty;
  assign timeout_err_o = err_q;
  assign batch_count_o = batch_q;
endmodule

// File: tb/tb_dnn_job_driver.sv
// Bench for dnn_job_driver: an 18-edge accelerator model echoes its operands, so every result
// must equal the vector that launched it; expected vectors are queued when driven.
module tb_dnn_job_driver;
  logic       clk;
  logic       rst_n;
  logic       clear_err;
  logic       busy;
  logic       timeout_err;
  logic [7:0] batch_count;

  dnn_job_driver_if bus_if ();

  dnn_job_driver #(
    .DEPTH    (4),
    .RES_DEPTH(4),
    .TIMEOUT  (63)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job_if       (bus_if),
    .clear_err_i  (clear_err),
    .busy_o       (busy),
    .timeout_err_o(timeout_err),
    .batch_count_o(batch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  int          exp_batch = 0;
  int          t_a;
  logic [31:0] v;
  logic [31:0] sb [$];
  int          rise_cyc [$];
  logic        m_hang;
  logic        m_busy;
  int          m_cnt;
  logic        prev_start;
  logic        prev_rv;
  logic [31:0] ops_cap;
  logic [31:0] ops;

  assign ops = {bus_if.acc_in_3, bus_if.acc_in_2, bus_if.acc_in_1, bus_if.acc_in_0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accelerator model: done 18 edges after start is sampled, held until start drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy           <= 1'b0;
      m_cnt            <= 0;
      bus_if.acc_done  <= 1'b0;
      bus_if.acc_valid <= 1'b0;
      bus_if.acc_out_0 <= '0;
      bus_if.acc_out_1 <= '0;
    end else if (bus_if.acc_done) begin
      if (!bus_if.acc_start) begin
        bus_if.acc_done  <= 1'b0;
        bus_if.acc_valid <= 1'b0;
      end
    end else if (m_busy) begin
      if (m_cnt == 18) begin
        m_busy           <= 1'b0;
        bus_if.acc_done  <= 1'b1;
        bus_if.acc_valid <= 1'b1;
        bus_if.acc_out_0 <= {bus_if.acc_in_1, bus_if.acc_in_0};
        bus_if.acc_out_1 <= {bus_if.acc_in_3, bus_if.acc_in_2};
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (bus_if.acc_start && !m_hang) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
    end
  end

  // Operands must not move while acc_start is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start <= 1'b0;
    end else if (bus_if.acc_start) begin
      if (prev_start) check("operands_stable", ops, ops_cap);
      else ops_cap <= ops;
      prev_start <= 1'b1;
    end else begin
      prev_start <= 1'b0;
    end
  end

  // Scoreboard: every accepted result is compared against the oldest expected vector.
  always @(negedge clk) begin
    if (rst_n && bus_if.res_valid && bus_if.res_ready) begin
      n_asserts++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_result: observed 0x%0h expected no result", bus_if.res_data);
      end
      if (sb.size() != 0) check("res_data", bus_if.res_data, sb.pop_front());
    end
    if (rst_n && bus_if.res_valid && !prev_rv) rise_cyc.push_back(cyc);
    prev_rv <= rst_n && bus_if.res_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string p);
    check({p, "_acc_start"}, {31'd0, bus_if.acc_start}, 32'd0);
    check({p, "_acc_in"}, ops, 32'd0);
    check({p, "_res_valid"}, {31'd0, bus_if.res_valid}, 32'd0);
    check({p, "_res_data"}, bus_if.res_data, 32'd0);
    check({p, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    check({p, "_batch_count"}, {24'd0, batch_count}, 32'd0);
    check({p, "_busy"}, {31'd0, busy}, 32'd0);
    check({p, "_in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && !bus_if.in_ready; i++) tick();
    check("in_ready_wait", {31'd0, bus_if.in_ready}, 32'd1);
  endtask

  task automatic wait_start(input int budget);
    for (int i = 0; i < budget && !bus_if.acc_start; i++) tick();
    check("start_wait", {31'd0, bus_if.acc_start}, 32'd1);
  endtask

  task automatic wait_res_valid(input int budget);
    for (int i = 0; i < budget && !bus_if.res_valid; i++) tick();
    check("res_valid_wait", {31'd0, bus_if.res_valid}, 32'd1);
  endtask

  task automatic wait_sb_empty(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_batch(input logic [7:0] target, input int budget);
    for (int i = 0; i < budget && batch_count != target; i++) tick();
    check("batch_wait", {24'd0, batch_count}, {24'd0, target});
  endtask

  task automatic push_vec(input logic [31:0] vec, input logic expect_result);
    bus_if.in_valid = 1'b1;
    bus_if.in_vec   = vec;
    wait_ready(200);
    if (expect_result) sb.push_back(vec);
    tick();
    bus_if.in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b1;
    clear_err        = 1'b0;
    m_hang           = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_vec    = '0;
    bus_if.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Single job: launch one edge after push, result 20 edges after launch.
    bus_if.res_ready = 1'b1;
    push_vec(32'h0403_0201, 1'b1);
    check("start_not_yet", {31'd0, bus_if.acc_start}, 32'd0);
    check("busy_after_push", {31'd0, busy}, 32'd1);
    tick();
    check("start_launch", {31'd0, bus_if.acc_start}, 32'd1);
    t_a = cyc;
    wait_res_valid(40);
    check("result_latency", cyc - t_a, 32'd20);
    exp_batch = 1;
    check("batch_single", {24'd0, batch_count}, exp_batch);
    check("start_fall", {31'd0, bus_if.acc_start}, 32'd0);
    tick();
    check("start_low_1", {31'd0, bus_if.acc_start}, 32'd0);
    tick();
    check("start_low_2", {31'd0, bus_if.acc_start}, 32'd0);
    wait_idle(20);

    // Queue full: five back-to-back vectors, results 23 cycles apart.
    rise_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      v = 32'h1111_1111 * (i + 1);
      bus_if.in_valid = 1'b1;
      bus_if.in_vec   = v;
      wait_ready(200);
      sb.push_back(v);
      tick();
      if (i == 3) begin
        check("in_ready_full", {31'd0, bus_if.in_ready}, 32'd0);
        check("first_job_running", {31'd0, bus_if.acc_start}, 32'd1);
      end
    end
    bus_if.in_valid = 1'b0;
    wait_sb_empty(300);
    wait_idle(20);
    exp_batch += 5;
    check("batch_after_burst", {24'd0, batch_count}, exp_batch);
    check("rise_count", rise_cyc.size(), 32'd5);
    for (int k = 1; k < rise_cyc.size(); k++)
      check("result_spacing", rise_cyc[k] - rise_cyc[k-1], 32'd23);

    // Result backpressure: four results stored, fifth job parks without timing out.
    bus_if.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_vec(32'h1020_3040 + i * 32'h0101_0101, 1'b1);
    wait_batch(8'(exp_batch + 4), 300);
    repeat (100) tick();
    check("park_start_high", {31'd0, bus_if.acc_start}, 32'd1);
    check("park_no_timeout", {31'd0, timeout_err}, 32'd0);
    check("park_batch", {24'd0, batch_count}, exp_batch + 4);
    check("park_res_valid", {31'd0, bus_if.res_valid}, 32'd1);
    check("park_busy", {31'd0, busy}, 32'd1);
    bus_if.res_ready = 1'b1;
    wait_sb_empty(300);
    wait_idle(50);
    exp_batch += 6;
    check("batch_after_backpressure", {24'd0, batch_count}, exp_batch);

    // Timeout: clear_err and the abort land on the same edge, the set wins.
    m_hang = 1'b1;
    push_vec(32'hDEAD_BEEF, 1'b0);
    wait_start(10);
    repeat (62) tick();
    check("no_early_timeout", {31'd0, timeout_err}, 32'd0);
    check("start_before_timeout", {31'd0, bus_if.acc_start}, 32'd1);
    clear_err = 1'b1;
    tick();
    check("timeout_set_wins", {31'd0, timeout_err}, 32'd1);
    check("timeout_start_drop", {31'd0, bus_if.acc_start}, 32'd0);
    check("timeout_no_result", {31'd0, bus_if.res_valid}, 32'd0);
    tick();
    check("clear_err", {31'd0, timeout_err}, 32'd0);
    clear_err = 1'b0;
    wait_idle(10);
    check("timeout_batch", {24'd0, batch_count}, exp_batch);
    m_hang = 1'b0;
    push_vec(32'h0102_0304, 1'b1);
    wait_sb_empty(60);
    wait_idle(20);
    exp_batch += 1;
    check("batch_after_timeout", {24'd0, batch_count}, exp_batch);

    // Reset ten cycles into a job.
    push_vec(32'h1234_5678, 1'b0);
    wait_start(10);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    rst_n = 1'b1;
    tick();
    push_vec(32'hA5A5_A5A5, 1'b1);
    wait_sb_empty(60);
    wait_idle(20);
    check("batch_after_reset", {24'd0, batch_count}, 32'd1);

    check("sb_final", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
